// File: rtl/tft_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tft_bus_arbiter_pkg
//   Shared definitions for the tft_spi bus arbiter and its winner picker.
//   Contents:
//     arb_state_t     arbiter FSM encoding (ARB_IDLE / ARB_OWN / ARB_DRAIN)
//     ARB_FIXED/RR    arbitration mode selectors
//     TFT_BYTE_W      width of one byte lane towards tft_spi
//     BYTE_COUNT_MAX  saturation value of the per-grant byte counter
// -----------------------------------------------------------------------------
package tft_bus_arbiter_pkg;

    localparam int TFT_BYTE_W = 8;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    localparam logic [15:0] BYTE_COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/tft_arb_pick.sv
// -----------------------------------------------------------------------------
// tft_arb_pick
//   Combinational winner selection for the tft_spi bus arbiter.
//   Scans the request vector starting at the rotate pointer (round-robin) or
//   at index 0 (fixed priority) and returns the first requester found.
//   Ports:
//     req         in   N_REQ   candidate requests
//     ptr         in   IDX_W   first index to consider in round-robin mode
//     mode        in   1       ARB_FIXED or ARB_RR
//     win_onehot  out  N_REQ   one-hot winner (all zero when nobody requests)
//     win_idx     out  IDX_W   index of the winner
//     win_valid   out  1       at least one request present
// -----------------------------------------------------------------------------
module tft_arb_pick
    import tft_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    int cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Rotation wraps by subtraction so N_REQ need not be a power of 2.
            cand = ((mode == ARB_RR) ? int'(ptr) : 0) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_valid && req[cand]) begin
                win_valid        = 1'b1;
                win_idx          = IDX_W'(cand);
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tft_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tft_bus_arbiter
//   Shares the single tft_spi byte transmitter between N_REQ display
//   requesters with a req/gnt handshake. An owner keeps the bus for a whole
//   burst; after it lets go the arbiter waits in DRAIN until tft_spi is idle
//   so a transfer in flight is never cut.
//   Optional feature macro: TFT_ARB_WATCHDOG_EN -- builds an idle-owner
//   watchdog that forces the grant into DRAIN after TIMEOUT_CYCLES.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     req            per-requester request/hold
//     data_in        byte per requester, lane i at [8i+7:8i]
//     dc_in          data/command flag per requester
//     transmit_in    one-cycle byte strobe per requester
//     gnt            registered one-hot grant
//     busy_out       per-requester busy (spi_busy for the owner, 1 otherwise)
//     spi_data/dc/transmit  muxed owner signals towards tft_spi
//     spi_busy       busy from tft_spi
//     owner          current owner index, valid while owner_valid
//     owner_valid    a grant is active
//     byte_count     bytes forwarded in the current grant (saturating)
//     timeout        sticky watchdog flag (0 without the macro)
// -----------------------------------------------------------------------------
module tft_bus_arbiter
    import tft_bus_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    localparam int IDX_W         = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [TFT_BYTE_W*N_REQ-1:0] data_in,
    input  logic [N_REQ-1:0]            dc_in,
    input  logic [N_REQ-1:0]            transmit_in,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            busy_out,
    output logic [TFT_BYTE_W-1:0]       spi_data,
    output logic                        spi_dc,
    output logic                        spi_transmit,
    input  logic                        spi_busy,
    output logic [IDX_W-1:0]            owner,
    output logic                        owner_valid,
    output logic [15:0]                 byte_count,
    output logic                        timeout
);

    // The watchdog needs at least one idle cycle before it can trip.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_too_small
    end

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      byte_count_q, byte_count_d;

    logic [N_REQ-1:0] req_eff;
    logic [N_REQ-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             own;
    logic             fwd;
    logic             wd_trip;

    assign own = (state_q == ARB_OWN);
    assign fwd = own && transmit_in[owner_q] && !spi_busy;

`ifdef TFT_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    // A requester whose grant was forced away is masked until it drops req.
    logic [N_REQ-1:0] blocked_q, blocked_d;

    assign wd_trip = own && !fwd && !spi_busy &&
                     (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign req_eff = req & ~blocked_q;
    assign timeout = timeout_q;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q | wd_trip;
        if (!own || fwd) begin
            wd_cnt_d = '0;
        end else if (!spi_busy && !wd_trip) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) begin
            blocked_d[i] = (blocked_q[i] && req[i]) ||
                           (wd_trip && (owner_q == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
            blocked_q <= '0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
            blocked_q <= blocked_d;
        end
    end
`else
    assign wd_trip = 1'b0;
    assign req_eff = req;
    assign timeout = 1'b0;
`endif

    tft_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req_eff),
        .ptr        (rr_ptr_q),
        .mode       ((ARB_MODE == 1) ? ARB_RR : ARB_FIXED),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    // State register (plus grant datapath flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            byte_count_q <= byte_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid && !spi_busy) begin
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if (!req[owner_q] || wd_trip) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (!spi_busy) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        byte_count_d = byte_count_q;

        if (state_q == ARB_IDLE && state_d == ARB_OWN) begin
            gnt_d        = win_onehot;
            owner_d      = win_idx;
            byte_count_d = '0;
            // Pointer lands just past the new owner, so it ranks last next time.
            rr_ptr_d     = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end

        if (own) begin
            if (fwd && byte_count_q != BYTE_COUNT_MAX) begin
                byte_count_d = byte_count_q + 16'd1;
            end
            if (state_d == ARB_DRAIN) begin
                gnt_d = '0;
            end
        end
    end

    assign spi_transmit = fwd;
    assign spi_data     = own ? data_in[owner_q*TFT_BYTE_W +: TFT_BYTE_W] : '0;
    assign spi_dc       = own && dc_in[owner_q];

    assign gnt          = gnt_q;
    assign owner        = owner_q;
    assign owner_valid  = own;
    assign byte_count   = byte_count_q;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_busy
        assign busy_out[gi] = gnt_q[gi] ? spi_busy : 1'b1;
    end

endmodule

// File: tb/tb_tft_bus_arbiter.sv
module tb_tft_bus_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_a, req_r, dc_in, transmit_in;
    logic [31:0]  data_in;
    logic         spi_busy;

    logic [N-1:0] gnt_a, busy_a, gnt_r, busy_r;
    logic [7:0]   spi_data_a, spi_data_r;
    logic         spi_dc_a, spi_dc_r, spi_tx_a, spi_tx_r;
    logic [1:0]   owner_a, owner_r;
    logic         owner_valid_a, owner_valid_r, timeout_a, timeout_r;
    logic [15:0]  byte_count_a, byte_count_r;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] q_a[$];
    logic [8:0] q_r[$];

    always #5 clk = ~clk;

    tft_bus_arbiter #(.N_REQ(N), .ARB_MODE(0), .TIMEOUT_CYCLES(16)) u_fixed (
        .clk(clk), .rst(rst), .req(req_a), .data_in(data_in), .dc_in(dc_in),
        .transmit_in(transmit_in), .gnt(gnt_a), .busy_out(busy_a),
        .spi_data(spi_data_a), .spi_dc(spi_dc_a), .spi_transmit(spi_tx_a),
        .spi_busy(spi_busy), .owner(owner_a), .owner_valid(owner_valid_a),
        .byte_count(byte_count_a), .timeout(timeout_a)
    );

    tft_bus_arbiter #(.N_REQ(N), .ARB_MODE(1), .TIMEOUT_CYCLES(16)) u_rr (
        .clk(clk), .rst(rst), .req(req_r), .data_in(data_in), .dc_in(dc_in),
        .transmit_in(transmit_in), .gnt(gnt_r), .busy_out(busy_r),
        .spi_data(spi_data_r), .spi_dc(spi_dc_r), .spi_transmit(spi_tx_r),
        .spi_busy(spi_busy), .owner(owner_r), .owner_valid(owner_valid_r),
        .byte_count(byte_count_r), .timeout(timeout_r)
    );

    // Scoreboards: every strobe reaching tft_spi must match the next expected byte.
    always @(negedge clk) begin
        logic [8:0] exp_b;
        if (spi_tx_a) begin
            vectors++;
            if (q_a.size() == 0) begin
                miscompares++;
                $display("FAIL fwd_fixed: got unexpected strobe dc/data=%h, required no strobe", {spi_dc_a, spi_data_a});
            end else begin
                exp_b = q_a.pop_front();
                if ({spi_dc_a, spi_data_a} !== exp_b) begin
                    miscompares++;
                    $display("FAIL fwd_fixed: got dc/data=%h, required %h", {spi_dc_a, spi_data_a}, exp_b);
                end else
                    $display("fixed byte dc/data=%h ok", exp_b);
            end
        end
        if (spi_tx_r) begin
            vectors++;
            if (q_r.size() == 0) begin
                miscompares++;
                $display("FAIL fwd_rr: got unexpected strobe dc/data=%h, required no strobe", {spi_dc_r, spi_data_r});
            end else begin
                exp_b = q_r.pop_front();
                if ({spi_dc_r, spi_data_r} !== exp_b) begin
                    miscompares++;
                    $display("FAIL fwd_rr: got dc/data=%h, required %h", {spi_dc_r, spi_data_r}, exp_b);
                end else
                    $display("rr byte dc/data=%h ok", exp_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({gnt_a, owner_valid_a, owner_a, byte_count_a, timeout_a, spi_tx_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_fixed: got gnt=%b ov=%b own=%0d bc=%0d to=%b tx=%b, required all 0",
                     gnt_a, owner_valid_a, owner_a, byte_count_a, timeout_a, spi_tx_a);
        end
        vectors++;
        if ({gnt_r, owner_valid_r, byte_count_r} !== '0) begin
            miscompares++;
            $display("FAIL reset_rr: got gnt=%b ov=%b bc=%0d, required all 0", gnt_r, owner_valid_r, byte_count_r);
        end
        $display("reset checked");
        rst = 1'b0;
    endtask

    task automatic test_fixed_priority();
        tick();
        req_a = 4'b0110;
        #1;
        vectors++;
        if (gnt_a !== 4'b0000) begin
            miscompares++;
            $display("FAIL gnt_latency: got %b, required 0000 before the edge", gnt_a);
        end
        tick();
        vectors++;
        if (gnt_a !== 4'b0010 || owner_a !== 2'd1 || owner_valid_a !== 1'b1 || byte_count_a !== 16'd0) begin
            miscompares++;
            $display("FAIL fixed_grant: got gnt=%b own=%0d ov=%b bc=%0d, required 0010/1/1/0",
                     gnt_a, owner_a, owner_valid_a, byte_count_a);
        end
        vectors++;
        if (busy_a !== 4'b1101) begin
            miscompares++;
            $display("FAIL busy_out: got %b, required 1101", busy_a);
        end
        $display("fixed grant gnt=%b owner=%0d", gnt_a, owner_a);
    endtask

    task automatic test_burst_drain();
        // byte 1 from owner 1, plus a non-owner strobe from requester 2 that must vanish
        data_in[15:8] = 8'hA5; dc_in[1] = 1'b1; transmit_in[1] = 1'b1;
        data_in[23:16] = 8'h3C; transmit_in[2] = 1'b1;
        q_a.push_back({1'b1, 8'hA5});
        tick();
        transmit_in = '0;
        data_in[15:8] = 8'h5A; dc_in[1] = 1'b0; transmit_in[1] = 1'b1;
        q_a.push_back({1'b0, 8'h5A});
        tick();
        // third byte coincides with the request falling: still forwarded
        data_in[15:8] = 8'h0F; dc_in[1] = 1'b1; transmit_in[1] = 1'b1; req_a[1] = 1'b0;
        q_a.push_back({1'b1, 8'h0F});
        tick();
        transmit_in = '0;
        spi_busy = 1'b1;
        vectors++;
        if (gnt_a !== 4'b0000 || owner_valid_a !== 1'b0 || byte_count_a !== 16'd3) begin
            miscompares++;
            $display("FAIL drain_entry: got gnt=%b ov=%b bc=%0d, required 0000/0/3", gnt_a, owner_valid_a, byte_count_a);
        end
        repeat (3) tick();
        vectors++;
        if (gnt_a !== 4'b0000) begin
            miscompares++;
            $display("FAIL drain_hold: got gnt=%b while spi_busy, required 0000", gnt_a);
        end
        spi_busy = 1'b0;
        tick();
        vectors++;
        if (gnt_a !== 4'b0000) begin
            miscompares++;
            $display("FAIL owner_gap: got gnt=%b, required 0000", gnt_a);
        end
        tick();
        vectors++;
        if (gnt_a !== 4'b0100 || owner_a !== 2'd2 || byte_count_a !== 16'd0) begin
            miscompares++;
            $display("FAIL next_owner: got gnt=%b own=%0d bc=%0d, required 0100/2/0", gnt_a, owner_a, byte_count_a);
        end
        $display("burst drained, new owner=%0d", owner_a);
    endtask

    task automatic test_non_owner_strobe();
        req_a = 4'b0001;
        repeat (3) tick();
        vectors++;
        if (gnt_a !== 4'b0001 || owner_a !== 2'd0) begin
            miscompares++;
            $display("FAIL owner0_grant: got gnt=%b own=%0d, required 0001/0", gnt_a, owner_a);
        end
        data_in[31:24] = 8'hEE; transmit_in[3] = 1'b1;
        #1;
        vectors++;
        if (spi_tx_a !== 1'b0 || busy_a[3] !== 1'b1 || busy_a[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL non_owner: got tx=%b busy=%b, required tx=0 busy[3]=1 busy[0]=0", spi_tx_a, busy_a);
        end
        tick();
        transmit_in = '0;
        vectors++;
        if (byte_count_a !== 16'd0) begin
            miscompares++;
            $display("FAIL non_owner_count: got %0d, required 0", byte_count_a);
        end
        $display("non-owner strobe ignored");
    endtask

    task automatic test_busy_and_reset();
        spi_busy = 1'b1;
        data_in[7:0] = 8'h77; dc_in[0] = 1'b0; transmit_in[0] = 1'b1;
        #1;
        vectors++;
        if (spi_tx_a !== 1'b0 || busy_a[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_drop: got tx=%b busy0=%b, required 0/1", spi_tx_a, busy_a[0]);
        end
        tick();
        transmit_in = '0;
        spi_busy = 1'b0;
        vectors++;
        if (byte_count_a !== 16'd0) begin
            miscompares++;
            $display("FAIL busy_count: got %0d, required 0", byte_count_a);
        end
        data_in[7:0] = 8'h99; transmit_in[0] = 1'b1;
        q_a.push_back({1'b0, 8'h99});
        tick();
        transmit_in = '0;
        vectors++;
        if (byte_count_a !== 16'd1) begin
            miscompares++;
            $display("FAIL count_one: got %0d, required 1", byte_count_a);
        end
        rst = 1'b1;
        tick();
        transmit_in[0] = 1'b1;
        #1;
        vectors++;
        if (gnt_a !== 4'b0000 || owner_valid_a !== 1'b0 || spi_tx_a !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got gnt=%b ov=%b tx=%b, required 0000/0/0", gnt_a, owner_valid_a, spi_tx_a);
        end
        transmit_in = '0;
        req_a = '0;
        rst = 1'b0;
        tick();
        $display("busy drop and mid-burst reset checked");
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] one = 4'b0001;
        req_r = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            int e = exp_order[i];
            vectors++;
            if (owner_r !== 2'(e) || gnt_r !== (one << e) || owner_valid_r !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got own=%0d gnt=%b, required own=%0d", i, owner_r, gnt_r, e);
            end else
                $display("rr grant %0d -> owner %0d", i, e);
            data_in[8*e +: 8] = 8'h10 + 8'(i); dc_in[e] = 1'b1; transmit_in[e] = 1'b1;
            q_r.push_back({1'b1, 8'h10 + 8'(i)});
            tick();
            transmit_in = '0;
            vectors++;
            if (byte_count_r !== 16'd1) begin
                miscompares++;
                $display("FAIL rr_count[%0d]: got %0d, required 1", i, byte_count_r);
            end
            req_r[e] = 1'b0;
            tick();
            req_r[e] = 1'b1;
            tick();
            tick();
        end
        req_r = '0;
        repeat (3) tick();
    endtask

    task automatic test_watchdog();
        req_a = 4'b1000;
        tick();
        vectors++;
        if (gnt_a !== 4'b1000) begin
            miscompares++;
            $display("FAIL wd_grant: got %b, required 1000", gnt_a);
        end
        repeat (20) tick();
`ifdef TFT_ARB_WATCHDOG_EN
        vectors++;
        if (gnt_a !== 4'b0000 || timeout_a !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_trip: got gnt=%b to=%b, required 0000/1", gnt_a, timeout_a);
        end
        repeat (4) tick();
        vectors++;
        if (gnt_a !== 4'b0000) begin
            miscompares++;
            $display("FAIL wd_block: got gnt=%b while req still held, required 0000", gnt_a);
        end
        req_a = '0;
        tick();
        req_a = 4'b1000;
        tick();
        tick();
        vectors++;
        if (gnt_a !== 4'b1000 || timeout_a !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_regrant: got gnt=%b to=%b, required 1000/1", gnt_a, timeout_a);
        end
`else
        vectors++;
        if (gnt_a !== 4'b1000 || timeout_a !== 1'b0 || owner_valid_a !== 1'b1) begin
            miscompares++;
            $display("FAIL no_wd_hold: got gnt=%b to=%b ov=%b, required 1000/0/1", gnt_a, timeout_a, owner_valid_a);
        end
`endif
        $display("watchdog scenario gnt=%b timeout=%b", gnt_a, timeout_a);
        req_a = '0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        req_a = '0; req_r = '0; dc_in = '0; transmit_in = '0;
        data_in = '0; spi_busy = 1'b0;
        test_reset();
        test_fixed_priority();
        test_burst_drain();
        test_non_owner_strobe();
        test_busy_and_reset();
        test_round_robin();
        test_watchdog();
        vectors++;
        if (q_a.size() != 0 || q_r.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d/%0d bytes never forwarded, required 0/0", q_a.size(), q_r.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
